// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared state type, dark pattern and hex segment table for seven_seg_mux
package seven_seg_pkg;

   typedef enum logic {BLANK, SHOW} seg_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Patterns are {g,f,e,d,c,b,a}, active-low
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0011000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b0100111;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational 4-bit hex to active-low seven-segment decoder
module seg_hex_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_mux.sv
// rtl/seven_seg_mux.sv - multiplexed hex seven-segment driver with blanking gaps and double-buffered digits
// Define SEVEN_SEG_LZB_EN to blank leading zero digits.
module seven_seg_mux
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int TICKS_PER_DIGIT = 1024,
   parameter int BLANK_TICKS     = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    frame_done
);

   localparam int TICK_MAX = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
   localparam int TW       = $clog2(TICK_MAX + 1);
   localparam int IW       = $clog2(NUM_DIGITS);
   localparam logic [TW-1:0] SHOW_LAST  = TW'(TICKS_PER_DIGIT - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   seg_state_t              state_q, state_d;
   logic [TW-1:0]           tick_q, tick_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, pending_q;
   logic                    pend_valid_q;
   logic                    boundary;
   logic                    digit_dark;
   logic [3:0]              cur_nibble;
   logic [6:0]              cur_seg;
   logic [6:0]              seg_d;
   logic [NUM_DIGITS-1:0]   anode_d;

   // idx only moves on SHOW->BLANK, so the digit about to be lit is always idx_q
   assign cur_nibble = shadow_q[{idx_q, 2'b00} +: 4];

   seg_hex_decode u_dec (
      .nibble (cur_nibble),
      .seg    (cur_seg)
   );

`ifdef SEVEN_SEG_LZB_EN
   always_comb begin
      digit_dark = (idx_q != '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(idx_q) && shadow_q[4*k +: 4] != 4'h0) digit_dark = 1'b0;
      end
   end
`else
   assign digit_dark = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q + 1'b1;
      idx_d    = idx_q;
      boundary = 1'b0;
      case (state_q)
         BLANK: begin
            if (tick_q == BLANK_LAST) begin
               state_d = SHOW;
               tick_d  = '0;
            end
         end
         SHOW: begin
            if (tick_q == SHOW_LAST) begin
               state_d  = BLANK;
               tick_d   = '0;
               boundary = (idx_q == IDX_LAST);
               idx_d    = boundary ? '0 : idx_q + 1'b1;
            end
         end
         default: state_d = BLANK;
      endcase
      if (!en) begin
         state_d  = BLANK;
         tick_d   = '0;
         idx_d    = '0;
         boundary = 1'b0;
      end
      // Outputs are derived from the next state so they switch on the same edge
      seg_d   = SEG_OFF;
      anode_d = '1;
      if (state_d == SHOW && !digit_dark) begin
         seg_d          = cur_seg;
         anode_d[idx_d] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= BLANK;
         tick_q       <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         pending_q    <= '0;
         pend_valid_q <= 1'b0;
         seg          <= SEG_OFF;
         anode        <= '1;
         frame_done   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         idx_q      <= idx_d;
         seg        <= seg_d;
         anode      <= anode_d;
         frame_done <= boundary;
         if (boundary && load) begin
            shadow_q     <= digits_i;
            pend_valid_q <= 1'b0;
         end else begin
            if (boundary && pend_valid_q) begin
               shadow_q     <= pending_q;
               pend_valid_q <= 1'b0;
            end
            if (load) begin
               pending_q    <= digits_i;
               pend_valid_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb/tb_seven_seg_mux.sv - scoreboard bench for seven_seg_mux (2-digit and 4-digit instances)
module tb_seven_seg_mux;

   localparam logic [6:0] OFF = 7'h7F;

   typedef struct {
      logic       sel;
      logic [3:0] an;
      logic [6:0] sg;
      logic       fd;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n, en, load2, load4;
   logic [7:0]  dig2;
   logic [15:0] dig4;
   logic [6:0]  seg2, seg4;
   logic [1:0]  anode2;
   logic [3:0]  anode4;
   logic        fd2, fd4;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;

   seven_seg_mux #(.NUM_DIGITS(2), .TICKS_PER_DIGIT(4), .BLANK_TICKS(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .en(en), .load(load2), .digits_i(dig2),
      .seg(seg2), .anode(anode2), .frame_done(fd2)
   );

   seven_seg_mux #(.NUM_DIGITS(4), .TICKS_PER_DIGIT(4), .BLANK_TICKS(1)) dut4 (
      .clk(clk), .reset_n(reset_n), .en(en), .load(load4), .digits_i(dig4),
      .seg(seg4), .anode(anode4), .frame_done(fd4)
   );

   function automatic logic [6:0] hex(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0011000;
         4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
         4'hC: s = 7'b0100111;  4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;  default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Inputs are already driven; queue what the next edge must produce, then pass that edge
   task automatic step(input logic sel, input logic [3:0] an, input logic [6:0] sg, input logic fd);
      exp_t e;
      e.sel = sel; e.an = an; e.sg = sg; e.fd = fd;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
      load2 = 1'b0;
      load4 = 1'b0;
   endtask

   // One 2-digit frame from a parked/boundary start: 4 lit d0, dark, 4 lit d1, boundary dark
   task automatic frame2(input logic [7:0] v, input int la, input logic [7:0] lv,
                         input int lb, input logic [7:0] lw);
      for (int i = 0; i < 10; i++) begin
         if (i == la) begin load2 = 1'b1; dig2 = lv; end
         if (i == lb) begin load2 = 1'b1; dig2 = lw; end
         if (i < 4)       step(1'b0, 4'b1110, hex(v[3:0]), 1'b0);
         else if (i == 4) step(1'b0, 4'b1111, OFF, 1'b0);
         else if (i < 9)  step(1'b0, 4'b1101, hex(v[7:4]), 1'b0);
         else             step(1'b0, 4'b1111, OFF, 1'b1);
      end
   endtask

   task automatic frame4(input logic [15:0] v);
      logic [3:0] an;
      logic [3:0] nib;
      logic       dark;
      for (int k = 0; k < 4; k++) begin
         nib  = v[4*k +: 4];
         dark = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
         dark = (k > 0) && ((v >> (4*k)) == 16'h0);
`endif
         an = 4'hF;
         if (!dark) an[k] = 1'b0;
         repeat (4) step(1'b1, an, dark ? OFF : hex(nib), 1'b0);
         step(1'b1, 4'hF, OFF, k == 3);
      end
   endtask

   always @(posedge clk) begin : monitor
      exp_t       e;
      logic [3:0] a_an;
      logic [6:0] a_sg;
      logic       a_fd;
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e    = exp_q.pop_front();
         a_an = e.sel ? anode4 : {2'b11, anode2};
         a_sg = e.sel ? seg4 : seg2;
         a_fd = e.sel ? fd4 : fd2;
         total++;
         if (a_an !== e.an || a_sg !== e.sg || a_fd !== e.fd) begin
            bad++;
            $display("FAIL outputs cyc%0d dut%0d: got anode=%b seg=%b fd=%b want anode=%b seg=%b fd=%b",
                     cyc, e.sel ? 4 : 2, a_an, a_sg, a_fd, e.an, e.sg, e.fd);
         end
      end
   end

   initial begin
      reset_n = 1'b0; en = 1'b1; load2 = 1'b0; load4 = 1'b0; dig2 = '0; dig4 = '0;
      #1;
      repeat (3) step(1'b0, 4'b1111, OFF, 1'b0);

      // release; 3A goes to pending, first frame still shows zeros
      reset_n = 1'b1;
      frame2(8'h00, 0, 8'h3A, -1, 8'h00);
      frame2(8'h3A, -1, 8'h00, -1, 8'h00);
      // two loads while digit 0 lit: last one wins at the boundary
      frame2(8'h3A, 1, 8'h12, 2, 8'h34);
      // load on the boundary edge goes straight to shadow
      frame2(8'h34, 9, 8'h5E, -1, 8'h00);
      frame2(8'h5E, -1, 8'h00, -1, 8'h00);

      // en drop in the middle of digit 1
      repeat (4) step(1'b0, 4'b1110, hex(4'hE), 1'b0);
      step(1'b0, 4'b1111, OFF, 1'b0);
      repeat (2) step(1'b0, 4'b1101, hex(4'h5), 1'b0);
      en = 1'b0;
      step(1'b0, 4'b1111, OFF, 1'b0);
      load2 = 1'b1; dig2 = 8'h7C;
      step(1'b0, 4'b1111, OFF, 1'b0);
      en = 1'b1;
      frame2(8'h5E, -1, 8'h00, -1, 8'h00);
      frame2(8'h7C, -1, 8'h00, -1, 8'h00);

      // reset mid-digit discards pending and shadow
      load2 = 1'b1; dig2 = 8'h99;
      repeat (3) step(1'b0, 4'b1110, hex(4'hC), 1'b0);
      reset_n = 1'b0;
      step(1'b0, 4'b1111, OFF, 1'b0);
      reset_n = 1'b1;
      frame2(8'h00, -1, 8'h00, -1, 8'h00);
      frame2(8'h00, -1, 8'h00, -1, 8'h00);

      // 4-digit instance, leading-zero behaviour
      reset_n = 1'b0;
      step(1'b0, 4'b1111, OFF, 1'b0);
      reset_n = 1'b1; en = 1'b0; load4 = 1'b1; dig4 = 16'h0070;
      step(1'b1, 4'b1111, OFF, 1'b0);
      en = 1'b1;
      frame4(16'h0000);
      frame4(16'h0070);

      @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish by 100000 want finish");
      $fatal(1);
   end

endmodule
